// File: rtl/mips_cpu_pkg.sv
// Purpose: shared types and encodings for the mips_cpu multicycle sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LWR    = 6'h26;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_JALR   = 6'h09;
    localparam logic [5:0] FN_ADDU   = 6'h21;

    localparam logic [1:0] PC_SEL_NEXT   = 2'd0;
    localparam logic [1:0] PC_SEL_TARGET = 2'd1;
    localparam logic [1:0] PC_SEL_HOLD   = 2'd2;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jump;
        logic writes_reg;
    } instr_class_t;

endpackage

// File: rtl/mips_cpu_sequencer_if.sv
// Purpose: Avalon-style instruction/data bus handshake between sequencer and memory.
// Latency: none (wires only).
// Backpressure: waitrequest from the slave holds the current access.
interface mips_cpu_sequencer_if;
    logic waitrequest;
    logic mem_read;
    logic mem_write;
    logic addr_sel;

    modport master (output mem_read, output mem_write, output addr_sel, input waitrequest);
    modport slave  (input mem_read, input mem_write, input addr_sel, output waitrequest);
endinterface

// File: rtl/mips_cpu_decode_class.sv
// Purpose: classify the held instruction into load/store/branch/jump/register-writer.
// Latency: combinational.
// Backpressure: none.
module mips_cpu_decode_class
    import mips_cpu_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls
);

    // Opcode ranges map directly to the instruction groups the FSM routes on.
    always_comb begin
        cls            = '0;
        cls.is_load    = (opcode >= OP_LB) && (opcode <= OP_LWR);
        cls.is_store   = (opcode >= OP_SB) && (opcode <= OP_SW);
        cls.is_branch  = (opcode == OP_REGIMM) || ((opcode >= OP_BEQ) && (opcode <= OP_BGTZ));
        cls.is_jump    = (opcode == OP_J) || (opcode == OP_JAL) ||
                         ((opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR)));
        cls.writes_reg = ((opcode == OP_RTYPE) && (funct != FN_JR)) ||
                         ((opcode >= OP_ADDI) && (opcode <= OP_LUI));
    end

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Purpose: multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with branch delay slot handling.
// Latency: 4 cycles for ALU ops, 5 for loads, plus one cycle per waitrequest stall.
// Backpressure: waitrequest holds FETCH/MEM; a stall run reaching WAIT_LIMIT halts with bus_error.
module mips_cpu_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_cpu_sequencer_if.master    bus,
    input  logic [5:0]              ir_opcode,
    input  logic [5:0]              ir_funct,
    input  logic                    sig_branch,
    input  logic                    link,
    input  logic                    pc_is_zero,
    output logic                    ir_write,
    output logic                    reg_write,
    output logic                    pc_write,
    output logic [1:0]              pc_sel,
    output logic                    target_latch,
    output logic [5:0]              alu_ctrl,
    output logic [5:0]              alu_opcode,
    output logic                    active,
    output logic                    bus_error
);

    localparam int             CW    = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(WAIT_LIMIT);

    seq_state_t    state;
    instr_class_t  cls;
    logic          delay_pending;  // a taken branch/jump is waiting for its delay slot to finish
    logic          in_slot;        // the instruction in flight is a delay slot
    logic          retarget;       // this instruction latched a new target earlier (EXEC before WB)
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_inc;
    logic          fetch_halt;
    logic          bus_busy;
    logic          wait_hit;
    logic          exec_final;

    mips_cpu_decode_class u_decode (
        .opcode (ir_opcode),
        .funct  (ir_funct),
        .cls    (cls)
    );

    assign wait_cnt_inc = wait_cnt + 1'b1;
    assign fetch_halt   = (state == ST_FETCH) && pc_is_zero && !delay_pending;
    assign bus_busy     = ((state == ST_FETCH) && !fetch_halt) || (state == ST_MEM);
    assign wait_hit     = bus_busy && bus.waitrequest && (WAIT_LIMIT != 0) && (wait_cnt_inc == LIMIT);
    assign exec_final   = !cls.is_load && !cls.is_store && !cls.writes_reg && !link;

    // Strobes follow state and waitrequest; reset suppresses them so an aborted access leaks nothing.
    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr_sel  = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        pc_write      = 1'b0;
        target_latch  = 1'b0;
        pc_sel        = PC_SEL_HOLD;
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    if (!fetch_halt) begin
                        bus.mem_read = 1'b1;
                        ir_write     = !bus.waitrequest;
                    end
                end
                ST_EXEC: begin
                    target_latch = cls.is_jump || (cls.is_branch && sig_branch);
                    pc_write     = exec_final;
                end
                ST_MEM: begin
                    bus.addr_sel  = 1'b1;
                    bus.mem_read  = cls.is_load;
                    bus.mem_write = cls.is_store;
                    pc_write      = cls.is_store && !bus.waitrequest;
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
        if (pc_write) begin
            pc_sel = in_slot ? PC_SEL_TARGET : PC_SEL_NEXT;
        end
    end

    // Sequencer state, delay-slot tracking, stall counter and registered status/ALU outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_FETCH;
            delay_pending <= 1'b0;
            in_slot       <= 1'b0;
            retarget      <= 1'b0;
            wait_cnt      <= '0;
            active        <= 1'b1;
            bus_error     <= 1'b0;
            alu_ctrl      <= FN_ADDU;
            alu_opcode    <= '0;
        end else begin
            alu_ctrl <= ((state == ST_DECODE) && (ir_opcode == OP_RTYPE)) ? ir_funct : FN_ADDU;
            if (state == ST_DECODE) begin
                alu_opcode <= ir_opcode;
            end

            // Closing an instruction leaves a slot pending only if it redirected the PC itself.
            if (pc_write) begin
                delay_pending <= retarget || target_latch;
                retarget      <= 1'b0;
            end else if (target_latch) begin
                delay_pending <= 1'b1;
                retarget      <= 1'b1;
            end

            if (bus_busy && bus.waitrequest) begin
                wait_cnt <= wait_cnt_inc;
            end else begin
                wait_cnt <= '0;
            end

            case (state)
                ST_FETCH: begin
                    if (fetch_halt) begin
                        state  <= ST_HALT;
                        active <= 1'b0;
                    end else if (wait_hit) begin
                        state     <= ST_HALT;
                        active    <= 1'b0;
                        bus_error <= 1'b1;
                    end else if (!bus.waitrequest) begin
                        state   <= ST_DECODE;
                        in_slot <= delay_pending;
                    end
                end
                ST_DECODE: state <= ST_EXEC;
                ST_EXEC: begin
                    if (cls.is_load || cls.is_store) begin
                        state <= ST_MEM;
                    end else if (cls.writes_reg || link) begin
                        state <= ST_WB;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (wait_hit) begin
                        state     <= ST_HALT;
                        active    <= 1'b0;
                        bus_error <= 1'b1;
                    end else if (!bus.waitrequest) begin
                        state <= cls.is_load ? ST_WB : ST_FETCH;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                default: begin
                    state  <= ST_HALT;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule
